// File: rtl/result_bus_arbiter_pkg.sv
// Shared definitions for the result bus arbiter and the stations that snoop the result bus.
package result_bus_arbiter_pkg;

   // Default lane field widths, so the stations and the arbiter pack the bus the same way.
   localparam int unsigned DEFAULT_SIZE               = 32;
   localparam int unsigned DEFAULT_STATION_COUNT      = 4;
   localparam int unsigned DEFAULT_STATION_INDEX_SIZE = 2;
   localparam int unsigned DEFAULT_BUS_COUNT          = 1;

   // Width of one packed bus lane: valid bit, source index and value.
   function automatic int lane_width(input int size, input int index_size);
      return 1 + index_size + size;
   endfunction

   // Increment an index modulo count, so STATION_COUNT need not be a power of two.
   function automatic int wrap_inc(input int idx, input int count);
      if (idx + 1 >= count) begin
         return 0;
      end
      return idx + 1;
   endfunction

endpackage

// File: rtl/result_bus_arbiter_round_robin_picker.sv
// Combinational round-robin picker: returns the first PICK_COUNT set request bits, scanning
// from pointer upwards with wrap-around at WIDTH. Pick k goes to output slot k.
module round_robin_picker
   import result_bus_arbiter_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int PICK_COUNT = 1,
   parameter int INDEX_SIZE = 2
) (
   input  logic [WIDTH-1:0]                 request,
   input  logic [INDEX_SIZE-1:0]            pointer,
   output logic [PICK_COUNT-1:0]            pick_valid,
   output logic [INDEX_SIZE*PICK_COUNT-1:0] pick_index
);

   int   taken;
   int   pos;
   logic hit;

   // Walk the rotated request vector and hand out picks in scan order.
   always_comb begin
      pick_valid = '0;
      pick_index = '0;
      taken      = 0;
      pos        = 0;
      hit        = 1'b0;
      for (int off = 0; off < WIDTH; off++) begin
         pos = int'(pointer) + off;
         if (pos >= WIDTH) begin
            pos = pos - WIDTH;
         end
         hit = 1'b0;
         // Constant-index select keeps the request lookup free of wide dynamic indices.
         for (int s = 0; s < WIDTH; s++) begin
            if (s == pos) begin
               hit = request[s];
            end
         end
         if (hit) begin
            for (int k = 0; k < PICK_COUNT; k++) begin
               if (k == taken) begin
                  pick_valid[k]                            = 1'b1;
                  pick_index[k*INDEX_SIZE +: INDEX_SIZE] = INDEX_SIZE'(pos);
               end
            end
            taken = taken + 1;
         end
      end
   end

endmodule

// File: rtl/result_bus_arbiter.sv
// Result bus arbiter: grants up to BUS_COUNT ready reservation stations per cycle in
// round-robin order, releases them and broadcasts their results on a registered bus.
module result_bus_arbiter
   import result_bus_arbiter_pkg::*;
#(
   parameter int SIZE               = DEFAULT_SIZE,
   parameter int STATION_COUNT      = DEFAULT_STATION_COUNT,
   parameter int STATION_INDEX_SIZE = DEFAULT_STATION_INDEX_SIZE,
   parameter int BUS_COUNT          = DEFAULT_BUS_COUNT
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic                                  flush,
   input  logic [STATION_COUNT-1:0]              station_ready,
   input  logic [SIZE*STATION_COUNT-1:0]         station_result,
   output logic [STATION_COUNT-1:0]              station_release,
   output logic [BUS_COUNT-1:0]                  bus_asserted,
   output logic [STATION_INDEX_SIZE*BUS_COUNT-1:0] bus_source,
   output logic [SIZE*BUS_COUNT-1:0]             bus_value
);

   localparam int IW = STATION_INDEX_SIZE;

   logic [IW-1:0]           rr_ptr_q;
   logic [IW-1:0]           rr_ptr_d;
   logic [BUS_COUNT-1:0]    pick_valid;
   logic [IW*BUS_COUNT-1:0] pick_index;
   logic [SIZE*BUS_COUNT-1:0] lane_value;
   logic                    grant_en;

   logic [BUS_COUNT-1:0]      bus_asserted_q;
   logic [IW*BUS_COUNT-1:0]   bus_source_q;
   logic [SIZE*BUS_COUNT-1:0] bus_value_q;

   // Releases must stay low while reset is held, even though reset is asynchronous.
   assign grant_en = ~flush & reset;

   round_robin_picker #(
      .WIDTH      (STATION_COUNT),
      .PICK_COUNT (BUS_COUNT),
      .INDEX_SIZE (IW)
   ) u_picker (
      .request    (station_ready),
      .pointer    (rr_ptr_q),
      .pick_valid (pick_valid),
      .pick_index (pick_index)
   );

   // Decode each lane's pick into a one-cycle release pulse for the granted station.
   always_comb begin
      station_release = '0;
      for (int k = 0; k < BUS_COUNT; k++) begin
         for (int s = 0; s < STATION_COUNT; s++) begin
            if (grant_en && pick_valid[k] && (pick_index[k*IW +: IW] == IW'(s))) begin
               station_release[s] = 1'b1;
            end
         end
      end
   end

   // Route the granted station's result onto each lane.
   always_comb begin
      lane_value = '0;
      for (int k = 0; k < BUS_COUNT; k++) begin
         for (int s = 0; s < STATION_COUNT; s++) begin
            if (pick_index[k*IW +: IW] == IW'(s)) begin
               lane_value[k*SIZE +: SIZE] = station_result[s*SIZE +: SIZE];
            end
         end
      end
   end

   // Advance the pointer past the last (highest-lane) grant; hold on flush or no grant.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_en) begin
         for (int k = 0; k < BUS_COUNT; k++) begin
            if (pick_valid[k]) begin
               rr_ptr_d = IW'(wrap_inc(int'(pick_index[k*IW +: IW]), STATION_COUNT));
            end
         end
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // Bus registers: ungranted lanes drop valid and keep stale source/value.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bus_asserted_q <= '0;
         bus_source_q   <= '0;
         bus_value_q    <= '0;
      end else if (flush) begin
         bus_asserted_q <= '0;
      end else begin
         bus_asserted_q <= pick_valid;
         for (int k = 0; k < BUS_COUNT; k++) begin
            if (pick_valid[k]) begin
               bus_source_q[k*IW +: IW]     <= pick_index[k*IW +: IW];
               bus_value_q[k*SIZE +: SIZE] <= lane_value[k*SIZE +: SIZE];
            end
         end
      end
   end

   assign bus_asserted = bus_asserted_q;
   assign bus_source   = bus_source_q;
   assign bus_value    = bus_value_q;

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Directed bench for result_bus_arbiter: one-lane instance for most scenarios, a two-lane
// instance for multi-lane grants. Stations are modelled by the bench dropping ready on release.
module tb_result_bus_arbiter;

   logic         clock = 1'b0;
   logic         reset;
   logic         flush;
   logic [3:0]   ready;
   logic [127:0] result;
   logic [3:0]   rel;
   logic [0:0]   bus_asserted;
   logic [1:0]   bus_source;
   logic [31:0]  bus_value;

   logic [3:0]   ready2;
   logic [127:0] result2;
   logic [3:0]   rel2;
   logic [1:0]   asserted2;
   logic [3:0]   source2;
   logic [63:0]  value2;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   result_bus_arbiter dut (
      .clock           (clock),
      .reset           (reset),
      .flush           (flush),
      .station_ready   (ready),
      .station_result  (result),
      .station_release (rel),
      .bus_asserted    (bus_asserted),
      .bus_source      (bus_source),
      .bus_value       (bus_value)
   );

   result_bus_arbiter #(
      .BUS_COUNT (2)
   ) dut2 (
      .clock           (clock),
      .reset           (reset),
      .flush           (1'b0),
      .station_ready   (ready2),
      .station_result  (result2),
      .station_release (rel2),
      .bus_asserted    (asserted2),
      .bus_source      (source2),
      .bus_value       (value2)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset  = 1'b0;
      flush  = 1'b0;
      ready  = 4'hF;
      result = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
      ready2 = 4'h0;
      result2 = '0;
      #1;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (rel !== 4'b0000) begin
            failures++;
            $display("FAIL reset_release cycle %0d: got %b want 0000", c, rel);
         end
         checks++;
         if (bus_asserted !== 1'b0) begin
            failures++;
            $display("FAIL reset_bus_asserted cycle %0d: got %b want 0", c, bus_asserted);
         end
         tick();
      end
      #3;
      reset = 1'b1;
      #1;
      checks++;
      if (rel !== 4'b0001) begin
         failures++;
         $display("FAIL first_grant_release: got %b want 0001", rel);
      end
      tick();
      ready = 4'h0;
      checks++;
      if (bus_asserted !== 1'b1 || bus_source !== 2'd0 || bus_value !== 32'hD0) begin
         failures++;
         $display("FAIL first_grant_bus: got %b/%0d/%h want 1/0/000000d0",
                  bus_asserted, bus_source, bus_value);
      end
   endtask

   // Pointer is 1 here; only station 2 requests.
   task automatic test_single_station();
      result[64 +: 32] = 32'h0000_1234;
      ready = 4'b0100;
      #1;
      checks++;
      if (rel !== 4'b0100) begin
         failures++;
         $display("FAIL single_release: got %b want 0100", rel);
      end
      tick();
      ready = 4'b0000;
      checks++;
      if (bus_asserted !== 1'b1 || bus_source !== 2'd2 || bus_value !== 32'h0000_1234) begin
         failures++;
         $display("FAIL single_bus: got %b/%0d/%h want 1/2/00001234",
                  bus_asserted, bus_source, bus_value);
      end
      tick();
      checks++;
      if (bus_asserted !== 1'b0) begin
         failures++;
         $display("FAIL single_bus_drop: got %b want 0", bus_asserted);
      end
   endtask

   task automatic test_round_robin();
      int         exp_seq[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
      int         back[4]    = '{0, 0, 0, 0};
      logic [3:0] exp_rel;
      logic [3:0] got_rel;
      // Reset pulse puts the pointer back at 0.
      reset = 1'b0;
      #1;
      checks++;
      if (bus_asserted !== 1'b0) begin
         failures++;
         $display("FAIL rr_reset_clear: got %b want 0", bus_asserted);
      end
      reset  = 1'b1;
      result = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
      ready  = 4'hF;
      for (int c = 0; c < 8; c++) begin
         #1;
         exp_rel = 4'b0001 << exp_seq[c];
         got_rel = rel;
         checks++;
         if (got_rel !== exp_rel) begin
            failures++;
            $display("FAIL rr_release cycle %0d: got %b want %b", c, got_rel, exp_rel);
         end
         tick();
         checks++;
         if (bus_asserted !== 1'b1 || int'(bus_source) != exp_seq[c] ||
             bus_value !== 32'hA0 + 32'(exp_seq[c])) begin
            failures++;
            $display("FAIL rr_bus cycle %0d: got %b/%0d/%h want 1/%0d", c, bus_asserted,
                     bus_source, bus_value, exp_seq[c]);
         end
         // Released stations drop ready for one cycle, then re-dispatch.
         for (int i = 0; i < 4; i++) begin
            if (back[i] > 0) begin
               back[i]--;
               if (back[i] == 0) ready[i] = 1'b1;
            end
         end
         for (int i = 0; i < 4; i++) begin
            if (got_rel[i]) begin
               ready[i] = 1'b0;
               back[i]  = 1;
            end
         end
      end
      ready = 4'h0;
      tick();
   endtask

   // Pointer is 0 here.
   task automatic test_wrap();
      ready = 4'b0010;
      #1;
      checks++;
      if (rel !== 4'b0010) begin
         failures++;
         $display("FAIL wrap_setup_release: got %b want 0010", rel);
      end
      tick();
      ready = 4'b1001;
      #1;
      checks++;
      if (rel !== 4'b1000) begin
         failures++;
         $display("FAIL wrap_first_release: got %b want 1000", rel);
      end
      tick();
      ready = 4'b0001;
      checks++;
      if (bus_source !== 2'd3 || bus_asserted !== 1'b1) begin
         failures++;
         $display("FAIL wrap_first_bus: got %b/%0d want 1/3", bus_asserted, bus_source);
      end
      #1;
      checks++;
      if (rel !== 4'b0001) begin
         failures++;
         $display("FAIL wrap_second_release: got %b want 0001", rel);
      end
      tick();
      ready = 4'b0000;
      checks++;
      if (bus_source !== 2'd0 || bus_asserted !== 1'b1) begin
         failures++;
         $display("FAIL wrap_second_bus: got %b/%0d want 1/0", bus_asserted, bus_source);
      end
   endtask

   // Pointer is 1 here and the bus still carries station 0's result.
   task automatic test_flush();
      flush = 1'b1;
      ready = 4'b0101;
      #1;
      checks++;
      if (rel !== 4'b0000) begin
         failures++;
         $display("FAIL flush_release: got %b want 0000", rel);
      end
      tick();
      checks++;
      if (bus_asserted !== 1'b0) begin
         failures++;
         $display("FAIL flush_bus: got %b want 0", bus_asserted);
      end
      flush = 1'b0;
      #1;
      checks++;
      if (rel !== 4'b0100) begin
         failures++;
         $display("FAIL post_flush_release: got %b want 0100", rel);
      end
      tick();
      ready = 4'b0001;
      checks++;
      if (bus_asserted !== 1'b1 || bus_source !== 2'd2) begin
         failures++;
         $display("FAIL post_flush_bus: got %b/%0d want 1/2", bus_asserted, bus_source);
      end
      #1;
      checks++;
      if (rel !== 4'b0001) begin
         failures++;
         $display("FAIL post_flush_second: got %b want 0001", rel);
      end
      tick();
      ready = 4'b0000;
   endtask

   task automatic test_two_lanes();
      result2 = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
      ready2  = 4'b1110;
      #1;
      checks++;
      if (rel2 !== 4'b0110) begin
         failures++;
         $display("FAIL lanes_release: got %b want 0110", rel2);
      end
      tick();
      ready2 = 4'b1000;
      checks++;
      if (asserted2 !== 2'b11 || source2 !== 4'b1001 || value2 !== {32'hB2, 32'hB1}) begin
         failures++;
         $display("FAIL lanes_bus: got %b/%b/%h want 11/1001/000000b2000000b1",
                  asserted2, source2, value2);
      end
      #1;
      checks++;
      if (rel2 !== 4'b1000) begin
         failures++;
         $display("FAIL lanes_second_release: got %b want 1000", rel2);
      end
      tick();
      ready2 = 4'b0000;
      checks++;
      if (asserted2 !== 2'b01 || source2[1:0] !== 2'd3 || value2[31:0] !== 32'hB3) begin
         failures++;
         $display("FAIL lanes_second_bus: got %b/%b/%h want 01/lane0=3/b3",
                  asserted2, source2, value2[31:0]);
      end
      tick();
      checks++;
      if (asserted2 !== 2'b00) begin
         failures++;
         $display("FAIL lanes_idle: got %b want 00", asserted2);
      end
   endtask

   // Pointer is 1 here.
   task automatic test_reset_mid_broadcast();
      ready = 4'b0010;
      tick();
      checks++;
      if (bus_asserted !== 1'b1) begin
         failures++;
         $display("FAIL midreset_setup: got %b want 1", bus_asserted);
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (bus_asserted !== 1'b0 || rel !== 4'b0000) begin
         failures++;
         $display("FAIL midreset_clear: got %b/%b want 0/0000", bus_asserted, rel);
      end
      ready = 4'b0000;
      reset = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_station();
      test_round_robin();
      test_wrap();
      test_flush();
      test_two_lanes();
      test_reset_mid_broadcast();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
